// File: rtl/cpu_control_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_control_sequencer
//
// Multi-cycle control unit for the 12-bit microcontroller datapath. After
// reset it streams PROG_DEPTH words into instruction memory, then runs a
// FETCH / DECODE / EXECUTE loop, producing every datapath control strobe.
// The datapath itself is purely structural.
//
// Parameters:
//   PROG_DEPTH  number of instruction words loaded after reset (1..256)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   LoadValid  in   program-load word present this cycle
//   LoadAddr   out  [7:0] instruction-memory write address during load
//   ImemWe     out  instruction-memory write strobe (LOAD only)
//   IR         in   [11:0] instruction-memory output, addressed by PC
//   ZeroFlag   in   registered ALU zero status, read only in EXECUTE
//   IrEn       out  instruction-register load enable (FETCH)
//   PcEn       out  PC load enable (EXECUTE, all opcodes except HLT)
//   Mux1Sel    out  next-PC select: 1 = IR[7:0] branch target, 0 = PC+1
//   Mux2Sel    out  ALU B select: 1 = data-memory read data, 0 = immediate
//   AluOp      out  [2:0] ALU operation
//   AccEn      out  accumulator load enable
//   DmemWe     out  data-memory write strobe
//   Halted     out  high while in HALT
// -----------------------------------------------------------------------------
module cpu_control_sequencer #(
  parameter int unsigned PROG_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        LoadValid,
  output logic [7:0]  LoadAddr,
  output logic        ImemWe,
  input  logic [11:0] IR,
  input  logic        ZeroFlag,
  output logic        IrEn,
  output logic        PcEn,
  output logic        Mux1Sel,
  output logic        Mux2Sel,
  output logic [2:0]  AluOp,
  output logic        AccEn,
  output logic        DmemWe,
  output logic        Halted
);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_HALT    = 3'd4
  } state_t;

  // Last load address; for PROG_DEPTH=256 this is 255 and the counter
  // wraps back to 0 naturally on the final write.
  localparam logic [7:0] LOAD_LAST = 8'(PROG_DEPTH - 1);

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_HLT = 4'b0001;
  localparam logic [3:0] OP_JMP = 4'b0010;
  localparam logic [3:0] OP_JZ  = 4'b0011;
  localparam logic [3:0] OP_LDA = 4'b0100;
  localparam logic [3:0] OP_STA = 4'b0101;

  localparam logic [2:0] ALU_PASS_B = 3'b111;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [11:0] r_lir;
  logic        w_lir_load;
  logic [3:0]  w_opcode;

  // Operand field of the latched instruction is consumed by the datapath
  // from IR directly; only the opcode bits matter here.
  logic        w_unused_lir;
  assign w_unused_lir = ^r_lir[7:0];

  assign w_opcode = r_lir[11:8];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Load counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Latched instruction register, captured at the end of DECODE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lir <= '0;
    end else if (w_lir_load) begin
      r_lir <= IR;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lir_load  = 1'b0;
    LoadAddr    = '0;
    ImemWe      = 1'b0;
    IrEn        = 1'b0;
    PcEn        = 1'b0;
    Mux1Sel     = 1'b0;
    Mux2Sel     = 1'b0;
    AluOp       = '0;
    AccEn       = 1'b0;
    DmemWe      = 1'b0;
    Halted      = 1'b0;

    case (r_state)
      S_LOAD: begin
        LoadAddr = r_cnt;
        ImemWe   = LoadValid;
        if (LoadValid) begin
          if (r_cnt == LOAD_LAST) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_FETCH;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end

      S_FETCH: begin
        IrEn        = 1'b1;
        w_state_nxt = S_DECODE;
      end

      S_DECODE: begin
        w_lir_load  = 1'b1;
        w_state_nxt = S_EXECUTE;
      end

      S_EXECUTE: begin
        PcEn        = 1'b1;
        w_state_nxt = S_FETCH;
        if (w_opcode[3]) begin
          // ALU-immediate group: low three opcode bits select the operation.
          AccEn   = 1'b1;
          Mux2Sel = 1'b0;
          AluOp   = w_opcode[2:0];
        end else begin
          case (w_opcode)
            OP_NOP: ;
            OP_HLT: begin
              PcEn        = 1'b0;
              w_state_nxt = S_HALT;
            end
            OP_JMP: Mux1Sel = 1'b1;
            OP_JZ:  Mux1Sel = ZeroFlag;
            OP_LDA: begin
              AccEn   = 1'b1;
              Mux2Sel = 1'b1;
              AluOp   = ALU_PASS_B;
            end
            OP_STA: DmemWe = 1'b1;
            default: ; // reserved opcodes behave as NOP
          endcase
        end
      end

      S_HALT: begin
        Halted = 1'b1;
      end

      default: begin
        w_state_nxt = S_LOAD;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_control_sequencer.sv
module tb_cpu_control_sequencer;

  logic        clk;
  logic        rst;
  logic        LoadValid;
  logic [7:0]  LoadAddr;
  logic        ImemWe;
  logic [11:0] IR;
  logic        ZeroFlag;
  logic        IrEn;
  logic        PcEn;
  logic        Mux1Sel;
  logic        Mux2Sel;
  logic [2:0]  AluOp;
  logic        AccEn;
  logic        DmemWe;
  logic        Halted;

  int unsigned checks = 0;
  int unsigned errors = 0;

  cpu_control_sequencer #(.PROG_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .LoadValid (LoadValid),
    .LoadAddr  (LoadAddr),
    .ImemWe    (ImemWe),
    .IR        (IR),
    .ZeroFlag  (ZeroFlag),
    .IrEn      (IrEn),
    .PcEn      (PcEn),
    .Mux1Sel   (Mux1Sel),
    .Mux2Sel   (Mux2Sel),
    .AluOp     (AluOp),
    .AccEn     (AccEn),
    .DmemWe    (DmemWe),
    .Halted    (Halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector layout:
  // {Halted, ImemWe, IrEn, PcEn, Mux1Sel, Mux2Sel, AluOp[2:0], AccEn, DmemWe}
  logic [10:0] ctl;
  assign ctl = {Halted, ImemWe, IrEn, PcEn, Mux1Sel, Mux2Sel, AluOp, AccEn, DmemWe};

  localparam logic [10:0] C_NONE  = 11'b0_0_0_0_0_0_000_0_0;
  localparam logic [10:0] C_WE    = 11'b0_1_0_0_0_0_000_0_0;
  localparam logic [10:0] C_FETCH = 11'b0_0_1_0_0_0_000_0_0;
  localparam logic [10:0] C_HALT  = 11'b1_0_0_0_0_0_000_0_0;

  task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_addr(input string tag, input logic [7:0] exp);
    checks++;
    assert (LoadAddr === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, LoadAddr, exp);
    end
  endtask

  // Entered just after a negedge in FETCH; returns just after the negedge
  // following EXECUTE. IR is scrambled during EXECUTE to show that decode
  // uses only the latched copy.
  task automatic run_instr(input string tag, input logic [11:0] ir, input logic zf,
                           input logic [10:0] exp_exec);
    IR = ir;
    #1 chk({tag, "_fetch"}, ctl, C_FETCH);
    @(negedge clk);
    #1 chk({tag, "_decode"}, ctl, C_NONE);
    @(negedge clk);
    IR       = 12'h1A5;
    ZeroFlag = zf;
    #1 chk({tag, "_exec"}, ctl, exp_exec);
    @(negedge clk);
  endtask

  logic [5:0]  stall_pat;
  logic [7:0]  stall_addr [6];
  int unsigned writes;

  initial begin
    rst       = 1'b1;
    LoadValid = 1'b0;
    IR        = '0;
    ZeroFlag  = 1'b0;

    // Reset values
    #2;
    chk("reset_ctl", ctl, C_NONE);
    chk_addr("reset_addr", 8'd0);
    LoadValid = 1'b1;
    #1 chk("reset_imemwe_follows", ctl, C_WE);

    // Start a load, abort it after two writes with an async reset
    @(negedge clk);
    rst = 1'b0;
    #1 chk_addr("load_a0", 8'd0);
    @(negedge clk);
    #1 chk_addr("load_a1", 8'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_addr("midload_rst_addr", 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full-rate load of 4 words
    for (int i = 0; i < 4; i++) begin
      #1 chk_addr($sformatf("load_addr%0d", i), 8'(i));
      chk($sformatf("load_we%0d", i), ctl, C_WE);
      @(negedge clk);
    end
    // Now in FETCH; LoadValid stays high and must not write

    run_instr("alu_imm_9A5", 12'h9A5, 1'b0, 11'b0_0_0_1_0_0_001_1_0);
    run_instr("jz_taken",    12'h340, 1'b1, 11'b0_0_0_1_1_0_000_0_0);
    run_instr("jz_not",      12'h340, 1'b0, 11'b0_0_0_1_0_0_000_0_0);
    run_instr("lda",         12'h410, 1'b0, 11'b0_0_0_1_0_1_111_1_0);
    run_instr("sta",         12'h511, 1'b1, 11'b0_0_0_1_0_0_000_0_1);
    run_instr("rsvd7",       12'h700, 1'b1, 11'b0_0_0_1_0_0_000_0_0);
    run_instr("rsvd6",       12'h6FF, 1'b1, 11'b0_0_0_1_0_0_000_0_0);
    run_instr("nop",         12'h0FF, 1'b1, 11'b0_0_0_1_0_0_000_0_0);
    run_instr("jmp",         12'h2AB, 1'b0, 11'b0_0_0_1_1_0_000_0_0);
    run_instr("alu_imm_F00", 12'hF00, 1'b0, 11'b0_0_0_1_0_0_111_1_0);
    run_instr("alu_imm_800", 12'h800, 1'b1, 11'b0_0_0_1_0_0_000_1_0);
    run_instr("hlt",         12'h100, 1'b1, C_NONE);

    // HALT holds with all strobes low
    for (int i = 0; i < 12; i++) begin
      IR = 12'(i * 37);
      #1 chk($sformatf("halt_%0d", i), ctl, C_HALT);
      @(negedge clk);
    end

    // Reset out of HALT, asynchronously
    #2 rst = 1'b1;
    #1 chk("halt_rst_ctl", ctl, C_WE);
    chk_addr("halt_rst_addr", 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Stalled load: valid pattern 1,0,0,1,1,1
    stall_pat  = 6'b111001; // bit i = cycle i
    stall_addr = '{8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd3};
    writes     = 0;
    for (int i = 0; i < 6; i++) begin
      LoadValid = stall_pat[i];
      #1 chk_addr($sformatf("stall_addr%0d", i), stall_addr[i]);
      chk($sformatf("stall_we%0d", i), ctl, stall_pat[i] ? C_WE : C_NONE);
      if (ImemWe === 1'b1) writes++;
      @(negedge clk);
    end
    checks++;
    assert (writes == 4) else begin
      errors++;
      $error("FAIL stall_write_count observed=%0d expected=4", writes);
    end

    LoadValid = 1'b1;
    run_instr("post_stall_sta", 12'h5C3, 1'b0, 11'b0_0_0_1_0_0_000_0_1);
    #1 chk("post_stall_fetch", ctl, C_FETCH);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_control_sequencer.md
# cpu_control_sequencer

Multi-cycle control unit for the 12-bit microcontroller datapath. It first sequences a program image into instruction memory, then runs a FETCH/DECODE/EXECUTE loop. In that loop it drives the PC enable, the next-PC multiplexer select (PC+1 versus branch target), the ALU operand multiplexer select, the ALU op, and the accumulator and data-memory write strobes. It is the only block that generates datapath control; the datapath itself stays purely structural.

## Interface
- PROG_DEPTH, 256, number of instruction words loaded after reset (legal range 1..256).
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- LoadValid  in  1  program-load word present this cycle.
- LoadAddr  out  8  instruction-memory write address during load.
- ImemWe  out  1  instruction-memory write strobe.
- IR  in  12  instruction word at instruction-memory output, addressed by PC.
- ZeroFlag  in  1  registered ALU zero status.
- IrEn  out  1  instruction-register load enable.
- PcEn  out  1  PC register load enable.
- Mux1Sel  out  1  next-PC select: 1 = branch target IR[7:0], 0 = PC+1.
- Mux2Sel  out  1  ALU B-operand select: 1 = data-memory read data, 0 = immediate IR[7:0].
- AluOp  out  3  ALU operation code.
- AccEn  out  1  accumulator load enable.
- DmemWe  out  1  data-memory write strobe (address IR[7:0], data = accumulator).
- Halted  out  1  high while in HALT.

## Operation
- FSM states:
  - LOAD (reset state), FETCH, DECODE, EXECUTE, HALT.
  - 3-bit state register.
  - 8-bit load counter.
  - 12-bit latched instruction register (LIR).
- LOAD:
  - ImemWe = LoadValid; LoadAddr = counter.
  - Each cycle with LoadValid=1, the counter increments.
  - When LoadValid=1 and counter = PROG_DEPTH-1: counter clears to 0 and the next state is FETCH.
  - LoadValid=0 stalls the load; the counter holds.
- FETCH: IrEn=1; next state is DECODE.
- DECODE: LIR <= IR; next state is EXECUTE.
- EXECUTE decodes LIR[11:8]. PcEn=1 for every opcode except HLT. Next state is FETCH, or HALT for HLT.
  - 0000 NOP: PcEn only.
  - 0001 HLT: no strobes; next state HALT.
  - 0010 JMP: Mux1Sel=1.
  - 0011 JZ: Mux1Sel = ZeroFlag, sampled in the EXECUTE cycle.
  - 0100 LDA: AccEn=1, Mux2Sel=1, AluOp=111 (pass B).
  - 0101 STA: DmemWe=1.
  - 0110, 0111: reserved; behave exactly as NOP.
  - 1xxx ALU-immediate: AccEn=1, Mux2Sel=0, AluOp=LIR[10:8].
- HALT: all strobes 0, Halted=1. Stays in HALT until rst.
- Outside EXECUTE, all of the following are 0: PcEn, Mux1Sel, Mux2Sel, AccEn, DmemWe, AluOp.
- ImemWe is 0 outside LOAD.
- All outputs are combinational functions of state, LIR, the counter and the inputs. No output depends on IR directly except through LIR.

## Timing
- Reset (async assert, any state or mid-load): state=LOAD, counter=0, LIR=0.
- Output values while rst is high:
  - LoadAddr=0.
  - ImemWe follows LoadValid.
  - All other outputs 0, including Halted.
- First rising edge after rst deasserts is a normal LOAD cycle.
- Load: one word per cycle at full rate. PROG_DEPTH valid cycles move the FSM to FETCH, which is first seen on the edge after the last write.
- Instruction latency:
  - Exactly 3 cycles (FETCH, DECODE, EXECUTE) for every non-HLT opcode, including a taken JZ.
  - PC and the accumulator update on the edge that ends EXECUTE.
- IR must be stable from the FETCH cycle through DECODE. The PC only changes after EXECUTE, so this holds.
- ZeroFlag is read only in EXECUTE. It reflects the result of the previous accumulator-writing instruction.
- PROG_DEPTH=256: the final load write is at LoadAddr=255. The counter then wraps to 0 with no extra cycle.
- PROG_DEPTH=1: one valid cycle at LoadAddr=0, then FETCH.

## Test plan
- Reset mid-load:
  - Stimulus: PROG_DEPTH=4; assert LoadValid for 2 cycles, then pulse rst.
  - Required: LoadAddr returns to 0 asynchronously. A following 4 valid cycles give ImemWe at addresses 0,1,2,3, and FETCH is reached on the next edge.
- Load stall:
  - Stimulus: LoadValid pattern 1,0,0,1,1,1 with PROG_DEPTH=4.
  - Required: LoadAddr holds at 1 during both stall cycles; exactly 4 writes occur.
- ALU-immediate:
  - Stimulus: IR=0x9A5.
  - Required: FETCH IrEn=1; DECODE no strobes; EXECUTE AccEn=1, Mux2Sel=0, AluOp=001, PcEn=1, Mux1Sel=0. Period 3 cycles.
- Conditional branch:
  - Stimulus: IR=0x340 with ZeroFlag=1, then again with ZeroFlag=0.
  - Required: EXECUTE Mux1Sel=1 then Mux1Sel=0; PcEn=1 in both cases.
- Memory ops:
  - Stimulus: IR=0x410, then 0x511, then 0x700.
  - Required: LDA gives AccEn=1, Mux2Sel=1, AluOp=111. STA gives DmemWe=1 and AccEn=0. Reserved 0x7 gives PcEn only.
- Halt:
  - Stimulus: IR=0x100.
  - Required: EXECUTE PcEn=0; Halted=1 from the next cycle onward and all strobes stay 0 for 10+ cycles. A rst pulse clears Halted and returns the FSM to LOAD.
